// File: rtl/rlim_seq_if.sv
// Request and mode-line bundle between the control-unit microsequencer and rlim_seq.
// The sequencer side takes the slave modport; the requester (or bench) takes master.
interface rlim_seq_if;
   logic       i_run;
   logic       i_fast;
   logic       i_fault;
   logic       o_stopped;
   logic       o_ls1;
   logic       o_ls2;
   logic       o_hs;
   logic       o_busy;
   logic [2:0] o_state;

   modport master (
      output i_run, i_fast, i_fault,
      input  o_stopped, o_ls1, o_ls2, o_hs, o_busy, o_state
   );

   modport slave (
      input  i_run, i_fast, i_fault,
      output o_stopped, o_ls1, o_ls2, o_hs, o_busy, o_state
   );
endinterface

// File: rtl/rlim_seq.sv
// Mode sequencer for rlim4: turns run/fast/fault requests into one-hot mode lines,
// enforcing start, shift and brake dwell times so no illegal mode jump reaches rlim4.
module rlim_seq #(
   parameter int DW      = 16,
   parameter int T_START = 130,
   parameter int T_SHIFT = 390,
   parameter int T_BRAKE = 260
) (
   input logic        i_clk,
   input logic        i_reset,
   rlim_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      LOW   = 3'd2,
      HIGH  = 3'd3,
      DOWN  = 3'd4,
      BRAKE = 3'd5
   } state_t;

   localparam logic [DW-1:0] LD_START = DW'(T_START - 1);
   localparam logic [DW-1:0] LD_SHIFT = DW'(T_SHIFT - 1);
   localparam logic [DW-1:0] LD_BRAKE = DW'(T_BRAKE - 1);

   state_t        state, state_nxt;
   logic [DW-1:0] cnt, cnt_nxt;
   logic          cnt_zero;

   logic stopped_q, ls1_q, ls2_q, hs_q, busy_q;
   logic stopped_d, ls1_d, ls2_d, hs_d, busy_d;

   assign cnt_zero = (cnt == '0);

   // Next state and counter; the counter saturates at zero unless an entry reloads it.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_zero ? '0 : cnt - DW'(1);
      case (state)
         IDLE: begin
            if (bus.i_run && !bus.i_fault) begin
               state_nxt = START;
               cnt_nxt   = LD_START;
            end
         end
         START: begin
            if (bus.i_fault || !bus.i_run) begin
               state_nxt = BRAKE;
               cnt_nxt   = LD_BRAKE;
            end else if (cnt_zero) begin
               state_nxt = LOW;
               cnt_nxt   = LD_SHIFT;
            end
         end
         LOW: begin
            if (bus.i_fault || !bus.i_run) begin
               state_nxt = BRAKE;
               cnt_nxt   = LD_BRAKE;
            end else if (bus.i_fast && cnt_zero) begin
               state_nxt = HIGH;
            end
         end
         HIGH: begin
            if (bus.i_fault) begin
               state_nxt = BRAKE;
               cnt_nxt   = LD_BRAKE;
            end else if (!bus.i_run || !bus.i_fast) begin
               state_nxt = DOWN;
               cnt_nxt   = LD_SHIFT;
            end
         end
         DOWN: begin
            if (bus.i_fault) begin
               state_nxt = BRAKE;
               cnt_nxt   = LD_BRAKE;
            end else if (cnt_zero && bus.i_run) begin
               state_nxt = LOW;
               cnt_nxt   = LD_SHIFT;
            end else if (cnt_zero) begin
               state_nxt = BRAKE;
               cnt_nxt   = LD_BRAKE;
            end
         end
         BRAKE: begin
            if (cnt_zero) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Mode lines are decoded from the next state so they leave a flop, not the state decode.
   always_comb begin
      stopped_d = 1'b0;
      ls1_d     = 1'b0;
      ls2_d     = 1'b0;
      hs_d      = 1'b0;
      busy_d    = 1'b1;
      case (state_nxt)
         START:   ls1_d = 1'b1;
         LOW:     ls2_d = 1'b1;
         HIGH:    hs_d  = 1'b1;
         DOWN:    ls2_d = 1'b1;
         BRAKE:   ls1_d = 1'b1;
         default: begin
            stopped_d = 1'b1;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         stopped_q <= 1'b1;
         ls1_q     <= 1'b0;
         ls2_q     <= 1'b0;
         hs_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         stopped_q <= stopped_d;
         ls1_q     <= ls1_d;
         ls2_q     <= ls2_d;
         hs_q      <= hs_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.o_stopped = stopped_q;
   assign bus.o_ls1     = ls1_q;
   assign bus.o_ls2     = ls2_q;
   assign bus.o_hs      = hs_q;
   assign bus.o_busy    = busy_q;
   assign bus.o_state   = state;

endmodule

// File: tb/tb_rlim_seq.sv
// Directed bench for rlim_seq with short dwell times (START 4, SHIFT 6, BRAKE 5).
module tb_rlim_seq;

   localparam int ST_IDLE  = 0;
   localparam int ST_START = 1;
   localparam int ST_LOW   = 2;
   localparam int ST_HIGH  = 3;
   localparam int ST_DOWN  = 4;
   localparam int ST_BRAKE = 5;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   rlim_seq_if bus ();

   rlim_seq #(
      .DW      (16),
      .T_START (4),
      .T_SHIFT (6),
      .T_BRAKE (5)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Expected mode pattern {stopped, ls1, ls2, hs} for a state code.
   function automatic logic [3:0] mode_of(input int st);
      case (st)
         ST_START: mode_of = 4'b0100;
         ST_LOW:   mode_of = 4'b0010;
         ST_HIGH:  mode_of = 4'b0001;
         ST_DOWN:  mode_of = 4'b0010;
         ST_BRAKE: mode_of = 4'b0100;
         default:  mode_of = 4'b1000;
      endcase
   endfunction

   task automatic expect_st(input string tag, input int st);
      logic [3:0] mode;
      mode = {bus.o_stopped, bus.o_ls1, bus.o_ls2, bus.o_hs};
      chk({tag, ".state"}, 32'(bus.o_state), 32'(st));
      chk({tag, ".mode"}, 32'(mode), 32'(mode_of(st)));
      chk({tag, ".onehot"}, 32'($countones(mode)), 32'd1);
      chk({tag, ".busy"}, 32'(bus.o_busy), (st == ST_IDLE) ? 32'd0 : 32'd1);
   endtask

   task automatic hold(input string tag, input int st, input int n);
      for (int i = 0; i < n; i++) begin
         expect_st(tag, st);
         tick();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus.i_run   = 1'b0;
      bus.i_fast  = 1'b0;
      bus.i_fault = 1'b0;

      // 1: reset then idle
      repeat (3) tick();
      expect_st("rst", ST_IDLE);
      rst = 1'b0;
      tick();
      hold("idle", ST_IDLE, 10);

      // 2: stop -> high with fast held
      bus.i_run  = 1'b1;
      bus.i_fast = 1'b1;
      tick();
      hold("up.start", ST_START, 4);
      hold("up.low", ST_LOW, 6);
      expect_st("up.high", ST_HIGH);

      // 3: drop run in HIGH -> DOWN, BRAKE, IDLE
      bus.i_run = 1'b0;
      tick();
      hold("dn.down", ST_DOWN, 6);
      hold("dn.brake", ST_BRAKE, 5);
      expect_st("dn.idle", ST_IDLE);

      // 4: fault pulse in LOW with cnt at 2; run held through BRAKE
      bus.i_run  = 1'b1;
      bus.i_fast = 1'b0;
      tick();
      hold("flt.start", ST_START, 4);
      hold("flt.low", ST_LOW, 3);
      expect_st("flt.low_c2", ST_LOW);
      bus.i_fault = 1'b1;
      tick();
      bus.i_fault = 1'b0;
      hold("flt.brake", ST_BRAKE, 5);
      hold("flt.idle", ST_IDLE, 1);
      expect_st("flt.restart", ST_START);
      bus.i_fast = 1'b1;
      tick();
      hold("flt.start2", ST_START, 3);
      hold("flt.low2", ST_LOW, 6);
      expect_st("flt.high", ST_HIGH);

      // 5: drop fast only, reassert at DOWN cycle 2
      bus.i_fast = 1'b0;
      tick();
      hold("sh.down12", ST_DOWN, 1);
      expect_st("sh.down2", ST_DOWN);
      bus.i_fast = 1'b1;
      tick();
      hold("sh.down", ST_DOWN, 4);
      hold("sh.low", ST_LOW, 6);
      expect_st("sh.high", ST_HIGH);

      // 6: reset from HIGH goes straight to IDLE
      rst = 1'b1;
      bus.i_run  = 1'b0;
      bus.i_fast = 1'b0;
      tick();
      rst = 1'b0;
      expect_st("rhi.idle", ST_IDLE);
      tick();
      expect_st("rhi.idle2", ST_IDLE);

      // fault and run together in IDLE stay IDLE
      bus.i_run   = 1'b1;
      bus.i_fault = 1'b1;
      tick();
      hold("fr.idle", ST_IDLE, 2);
      bus.i_fault = 1'b0;
      tick();

      // run dropping as START expires goes to BRAKE, not LOW
      hold("rx.start", ST_START, 3);
      expect_st("rx.start_last", ST_START);
      bus.i_run = 1'b0;
      tick();
      hold("rx.brake", ST_BRAKE, 5);
      expect_st("rx.idle", ST_IDLE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

endmodule
